// File: rtl/ddr5_bank_sequencer.sv
`default_nettype none
// ==========================================================================
// ddr5_bank_sequencer : per-channel DDR5 ACT/CAS/PRE/REF command sequencer
// Revision 1.0
// ==========================================================================
module ddr5_bank_sequencer #(
   parameter int BG_W      = 3,
   parameter int BA_W      = 2,
   parameter int ROW_W     = 16,
   parameter int COL_W     = 10,
   parameter int T_RCD     = 3,
   parameter int T_RP      = 3,
   parameter int T_RFC     = 8,
   parameter int OPEN_PAGE = 0,
   localparam int ADDR_W   = (ROW_W > COL_W) ? ROW_W : COL_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [BG_W-1:0]   req_bg,
   input  logic [BA_W-1:0]   req_bank,
   input  logic [ROW_W-1:0]  req_row,
   input  logic [COL_W-1:0]  req_col,
   input  logic              ref_req,
   output logic              ref_ack,
   output logic [3:0]        cmd,
   output logic [BG_W-1:0]   cmd_bg,
   output logic [BA_W-1:0]   cmd_bank,
   output logic              cmd_all,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              cmd_row_col,
   output logic              done,
   output logic              page_hit
);
   localparam int BK_W   = BG_W + BA_W;
   localparam int N_BANK = 1 << BK_W;
   localparam int T_MAX  = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                          : ((T_RP  > T_RFC) ? T_RP  : T_RFC);
   localparam int CNT_W  = $clog2(T_MAX) + 1;

   localparam logic [3:0] CMD_NOP  = 4'd0;
   localparam logic [3:0] CMD_ACT0 = 4'd1;
   localparam logic [3:0] CMD_ACT1 = 4'd2;
   localparam logic [3:0] CMD_RD0  = 4'd3;
   localparam logic [3:0] CMD_RD1  = 4'd4;
   localparam logic [3:0] CMD_WR0  = 4'd5;
   localparam logic [3:0] CMD_WR1  = 4'd6;
   localparam logic [3:0] CMD_PRE  = 4'd7;
   localparam logic [3:0] CMD_REF  = 4'd8;

   // What follows the precharge wait: re-activate, return idle, or refresh
   localparam logic [1:0] PM_CONFLICT = 2'd0;
   localparam logic [1:0] PM_CLOSE    = 2'd1;
   localparam logic [1:0] PM_REFRESH  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_WRP, S_ACT0, S_ACT1, S_WRCD, S_CAS0, S_CAS1, S_REF, S_WRFC
   } state_t;

   state_t            state, next_state;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [1:0]        pre_mode, pre_mode_d;

   logic              lat_op;
   logic [BG_W-1:0]   lat_bg;
   logic [BA_W-1:0]   lat_bank;
   logic [ROW_W-1:0]  lat_row;
   logic [COL_W-1:0]  lat_col;

   logic [N_BANK-1:0] open_bits;
   logic [ROW_W-1:0]  open_row [N_BANK];

   logic [BK_W-1:0]   req_idx, f_idx;
   logic              req_open, req_hit, accept;
   logic              f_op;
   logic [BG_W-1:0]   f_bg;
   logic [BA_W-1:0]   f_bank;
   logic [ROW_W-1:0]  f_row;
   logic [COL_W-1:0]  f_col;

   logic [3:0]        cmd_d;
   logic [BG_W-1:0]   bg_d;
   logic [BA_W-1:0]   bank_d;
   logic [ADDR_W-1:0] addr_d;
   logic              all_d, rc_d, done_d, hit_d, ready_d, ack_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      req_idx    = {req_bg, req_bank};
      req_open   = open_bits[req_idx];
      req_hit    = req_open && (open_row[req_idx] == req_row);
      accept     = (state == S_IDLE) && req_valid && req_ready;
      // Fields of the current request: live inputs in the accept cycle, latched afterwards
      f_op       = accept ? req_op   : lat_op;
      f_bg       = accept ? req_bg   : lat_bg;
      f_bank     = accept ? req_bank : lat_bank;
      f_row      = accept ? req_row  : lat_row;
      f_col      = accept ? req_col  : lat_col;
      f_idx      = {f_bg, f_bank};

      next_state = state;
      cnt_d      = cnt;
      pre_mode_d = pre_mode;

      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_hit) begin
                  next_state = S_CAS0;
               end else if (req_open) begin
                  next_state = S_PRE;
                  pre_mode_d = PM_CONFLICT;
               end else begin
                  next_state = S_ACT0;
               end
            end else if (ref_req) begin
               if (|open_bits) begin
                  next_state = S_PRE;
                  pre_mode_d = PM_REFRESH;
               end else begin
                  next_state = S_REF;
               end
            end
         end
         S_PRE: begin
            next_state = S_WRP;
            cnt_d      = CNT_W'(T_RP);
         end
         S_WRP: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               case (pre_mode)
                  PM_REFRESH: next_state = S_REF;
                  PM_CLOSE:   next_state = S_IDLE;
                  default:    next_state = S_ACT0;
               endcase
            end
         end
         S_ACT0: next_state = S_ACT1;
         S_ACT1: begin
            next_state = S_WRCD;
            cnt_d      = CNT_W'(T_RCD);
         end
         S_WRCD: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CNT_W'(1)) next_state = S_CAS0;
         end
         S_CAS0: next_state = S_CAS1;
         S_CAS1: begin
            if (OPEN_PAGE != 0) begin
               next_state = S_IDLE;
            end else begin
               next_state = S_PRE;
               pre_mode_d = PM_CLOSE;
            end
         end
         S_REF: begin
            next_state = S_WRFC;
            cnt_d      = CNT_W'(T_RFC);
         end
         S_WRFC: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CNT_W'(1)) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      cmd_d   = CMD_NOP;
      bg_d    = '0;
      bank_d  = '0;
      addr_d  = '0;
      all_d   = 1'b0;
      rc_d    = 1'b0;
      done_d  = (next_state == S_CAS1);
      hit_d   = accept && req_hit;
      ack_d   = (state == S_WRFC) && (next_state == S_IDLE);
      // The refresh being acknowledged must not block a waiting request
      ready_d = (next_state == S_IDLE) && (!ref_req || state == S_WRFC);

      case (next_state)
         S_ACT0, S_ACT1: begin
            cmd_d              = (next_state == S_ACT0) ? CMD_ACT0 : CMD_ACT1;
            bg_d               = f_bg;
            bank_d             = f_bank;
            addr_d[ROW_W-1:0]  = f_row;
         end
         S_CAS0, S_CAS1: begin
            if (next_state == S_CAS0) cmd_d = f_op ? CMD_WR0 : CMD_RD0;
            else                      cmd_d = f_op ? CMD_WR1 : CMD_RD1;
            bg_d               = f_bg;
            bank_d             = f_bank;
            addr_d[COL_W-1:0]  = f_col;
            rc_d               = 1'b1;
         end
         S_PRE: begin
            cmd_d = CMD_PRE;
            if (pre_mode_d == PM_REFRESH) begin
               all_d = 1'b1;
            end else begin
               bg_d   = f_bg;
               bank_d = f_bank;
            end
         end
         S_REF: begin
            cmd_d = CMD_REF;
            all_d = 1'b1;
         end
         default: cmd_d = CMD_NOP;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         pre_mode    <= PM_CONFLICT;
         lat_op      <= 1'b0;
         lat_bg      <= '0;
         lat_bank    <= '0;
         lat_row     <= '0;
         lat_col     <= '0;
         open_bits   <= '0;
         for (int i = 0; i < N_BANK; i++) open_row[i] <= '0;
         cmd         <= CMD_NOP;
         cmd_bg      <= '0;
         cmd_bank    <= '0;
         cmd_all     <= 1'b0;
         cmd_addr    <= '0;
         cmd_row_col <= 1'b0;
         done        <= 1'b0;
         page_hit    <= 1'b0;
         req_ready   <= 1'b0;
         ref_ack     <= 1'b0;
      end else begin
         cnt      <= cnt_d;
         pre_mode <= pre_mode_d;
         if (accept) begin
            lat_op   <= req_op;
            lat_bg   <= req_bg;
            lat_bank <= req_bank;
            lat_row  <= req_row;
            lat_col  <= req_col;
         end
         if (state == S_ACT0) begin
            open_bits[f_idx] <= 1'b1;
            open_row[f_idx]  <= f_row;
         end
         if (next_state == S_PRE) begin
            if (pre_mode_d == PM_REFRESH) open_bits <= '0;
            else                          open_bits[f_idx] <= 1'b0;
         end
         cmd         <= cmd_d;
         cmd_bg      <= bg_d;
         cmd_bank    <= bank_d;
         cmd_all     <= all_d;
         cmd_addr    <= addr_d;
         cmd_row_col <= rc_d;
         done        <= done_d;
         page_hit    <= hit_d;
         req_ready   <= ready_d;
         ref_ack     <= ack_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ddr5_bank_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_ddr5_bank_sequencer : directed bench, close-page and open-page instances
// Revision 1.0
// ==========================================================================
module tb_ddr5_bank_sequencer;
   localparam logic [3:0] NOP = 4'd0, ACT0 = 4'd1, ACT1 = 4'd2, RD0 = 4'd3, RD1 = 4'd4;
   localparam logic [3:0] WR0 = 4'd5, WR1 = 4'd6, PRE = 4'd7, REF = 4'd8;

   logic clock;
   logic c_reset, c_req_valid, c_req_ready, c_req_op, c_ref_req, c_ref_ack;
   logic [2:0] c_req_bg, c_cmd_bg;
   logic [1:0] c_req_bank, c_cmd_bank;
   logic [15:0] c_req_row, c_cmd_addr;
   logic [9:0] c_req_col;
   logic [3:0] c_cmd;
   logic c_cmd_all, c_cmd_row_col, c_done, c_page_hit;

   logic o_reset, o_req_valid, o_req_ready, o_req_op, o_ref_req, o_ref_ack;
   logic [2:0] o_req_bg, o_cmd_bg;
   logic [1:0] o_req_bank, o_cmd_bank;
   logic [15:0] o_req_row, o_cmd_addr;
   logic [9:0] o_req_col;
   logic [3:0] o_cmd;
   logic o_cmd_all, o_cmd_row_col, o_done, o_page_hit;

   int n_pass  = 0;
   int n_total = 0;

   ddr5_bank_sequencer #(.OPEN_PAGE(0)) dut_cp (
      .clock(clock), .reset(c_reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_op(c_req_op), .req_bg(c_req_bg), .req_bank(c_req_bank), .req_row(c_req_row),
      .req_col(c_req_col), .ref_req(c_ref_req), .ref_ack(c_ref_ack), .cmd(c_cmd),
      .cmd_bg(c_cmd_bg), .cmd_bank(c_cmd_bank), .cmd_all(c_cmd_all), .cmd_addr(c_cmd_addr),
      .cmd_row_col(c_cmd_row_col), .done(c_done), .page_hit(c_page_hit));

   ddr5_bank_sequencer #(.OPEN_PAGE(1)) dut_op (
      .clock(clock), .reset(o_reset), .req_valid(o_req_valid), .req_ready(o_req_ready),
      .req_op(o_req_op), .req_bg(o_req_bg), .req_bank(o_req_bank), .req_row(o_req_row),
      .req_col(o_req_col), .ref_req(o_ref_req), .ref_ack(o_ref_ack), .cmd(o_cmd),
      .cmd_bg(o_cmd_bg), .cmd_bank(o_cmd_bank), .cmd_all(o_cmd_all), .cmd_addr(o_cmd_addr),
      .cmd_row_col(o_cmd_row_col), .done(o_done), .page_hit(o_page_hit));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // od selects the open-page instance; checks every output in the current cycle
   task automatic exp_cycle(input bit od, input string tag, input logic [3:0] ecmd,
                            input logic [2:0] ebg, input logic [1:0] eba, input logic [15:0] eaddr,
                            input logic erc, input logic eall, input logic edone,
                            input logic ehit, input logic eready, input logic eack);
      chk({tag, ".cmd"},      od ? o_cmd         : c_cmd,         ecmd);
      chk({tag, ".bg"},       od ? o_cmd_bg      : c_cmd_bg,      ebg);
      chk({tag, ".bank"},     od ? o_cmd_bank    : c_cmd_bank,    eba);
      chk({tag, ".addr"},     od ? o_cmd_addr    : c_cmd_addr,    eaddr);
      chk({tag, ".row_col"},  od ? o_cmd_row_col : c_cmd_row_col, erc);
      chk({tag, ".all"},      od ? o_cmd_all     : c_cmd_all,     eall);
      chk({tag, ".done"},     od ? o_done        : c_done,        edone);
      chk({tag, ".page_hit"}, od ? o_page_hit    : c_page_hit,    ehit);
      chk({tag, ".req_ready"},od ? o_req_ready   : c_req_ready,   eready);
      chk({tag, ".ref_ack"},  od ? o_ref_ack     : c_ref_ack,     eack);
   endtask

   task automatic nops(input bit od, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         exp_cycle(od, tag, NOP, 3'd0, 2'd0, 16'h0, 0, 0, 0, 0, 0, 0);
         tick();
      end
   endtask

   initial begin
      c_reset = 1; c_req_valid = 0; c_req_op = 0; c_req_bg = 0; c_req_bank = 0;
      c_req_row = 0; c_req_col = 0; c_ref_req = 0;
      o_reset = 1; o_req_valid = 0; o_req_op = 0; o_req_bg = 0; o_req_bank = 0;
      o_req_row = 0; o_req_col = 0; o_ref_req = 0;
      tick(); tick();
      exp_cycle(0, "c_reset", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
      exp_cycle(1, "o_reset", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
      c_reset = 0; o_reset = 0;
      tick();

      // Close-page closed-bank read, accept at cycle 0
      exp_cycle(0, "c_idle", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      c_req_valid = 1; c_req_op = 0; c_req_bg = 1; c_req_bank = 2;
      c_req_row = 16'h0ABC; c_req_col = 10'h155;
      tick();
      c_req_valid = 0; c_req_bg = 7; c_req_bank = 3; c_req_row = 16'hFFFF; c_req_col = 10'h3FF;
      exp_cycle(0, "c_act0", ACT0, 1, 2, 16'h0ABC, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(0, "c_act1", ACT1, 1, 2, 16'h0ABC, 0, 0, 0, 0, 0, 0); tick();
      nops(0, 3, "c_trcd");
      exp_cycle(0, "c_rd0", RD0, 1, 2, 16'h0155, 1, 0, 0, 0, 0, 0); tick();
      exp_cycle(0, "c_rd1", RD1, 1, 2, 16'h0155, 1, 0, 1, 0, 0, 0); tick();
      exp_cycle(0, "c_pre", PRE, 1, 2, 16'h0, 0, 0, 0, 0, 0, 0); tick();
      nops(0, 3, "c_trp");
      exp_cycle(0, "c_ready12", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);

      // Open-page write to bg2/bk1/row 0x1234
      exp_cycle(1, "o_idle", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      o_req_valid = 1; o_req_op = 1; o_req_bg = 2; o_req_bank = 1;
      o_req_row = 16'h1234; o_req_col = 10'h010;
      tick();
      o_req_valid = 0;
      exp_cycle(1, "o_wr_act0", ACT0, 2, 1, 16'h1234, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_wr_act1", ACT1, 2, 1, 16'h1234, 0, 0, 0, 0, 0, 0); tick();
      nops(1, 3, "o_wr_trcd");
      exp_cycle(1, "o_wr0", WR0, 2, 1, 16'h0010, 1, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_wr1", WR1, 2, 1, 16'h0010, 1, 0, 1, 0, 0, 0); tick();

      // Same row read: page hit, RD0 directly after accept
      exp_cycle(1, "o_idle2", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      o_req_valid = 1; o_req_op = 0; o_req_col = 10'h020;
      tick();
      o_req_valid = 0;
      exp_cycle(1, "o_hit_rd0", RD0, 2, 1, 16'h0020, 1, 0, 0, 1, 0, 0); tick();
      exp_cycle(1, "o_hit_rd1", RD1, 2, 1, 16'h0020, 1, 0, 1, 0, 0, 0); tick();

      // Row conflict: row 0x0042 in the same bank
      exp_cycle(1, "o_idle3", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      o_req_valid = 1; o_req_row = 16'h0042; o_req_col = 10'h030;
      tick();
      o_req_valid = 0;
      exp_cycle(1, "o_cf_pre", PRE, 2, 1, 16'h0, 0, 0, 0, 0, 0, 0); tick();
      nops(1, 3, "o_cf_trp");
      exp_cycle(1, "o_cf_act0", ACT0, 2, 1, 16'h0042, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_cf_act1", ACT1, 2, 1, 16'h0042, 0, 0, 0, 0, 0, 0); tick();
      nops(1, 3, "o_cf_trcd");
      exp_cycle(1, "o_cf_rd0", RD0, 2, 1, 16'h0030, 1, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_cf_rd1", RD1, 2, 1, 16'h0030, 1, 0, 1, 0, 0, 0); tick();

      // Refresh with a bank open
      exp_cycle(1, "o_idle4", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      o_ref_req = 1;
      tick();
      exp_cycle(1, "o_rf_preall", PRE, 0, 0, 16'h0, 0, 1, 0, 0, 0, 0); tick();
      nops(1, 3, "o_rf_trp");
      exp_cycle(1, "o_rf_ref", REF, 0, 0, 16'h0, 0, 1, 0, 0, 0, 0); tick();
      nops(1, 8, "o_rf_trfc");
      exp_cycle(1, "o_rf_ack", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 1);
      o_ref_req = 0;
      tick();
      exp_cycle(1, "o_rf_after", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);

      // Read to bg0/bk0, then refresh and a new request arrive together while busy
      o_req_valid = 1; o_req_op = 0; o_req_bg = 0; o_req_bank = 0;
      o_req_row = 16'h0005; o_req_col = 10'h007;
      tick();
      exp_cycle(1, "o_b_act0", ACT0, 0, 0, 16'h0005, 0, 0, 0, 0, 0, 0);
      o_ref_req = 1; o_req_bg = 3; o_req_bank = 2; o_req_row = 16'h0077; o_req_col = 10'h009;
      tick();
      exp_cycle(1, "o_b_act1", ACT1, 0, 0, 16'h0005, 0, 0, 0, 0, 0, 0); tick();
      nops(1, 3, "o_b_trcd");
      exp_cycle(1, "o_b_rd0", RD0, 0, 0, 16'h0007, 1, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_b_rd1", RD1, 0, 0, 16'h0007, 1, 0, 1, 0, 0, 0); tick();
      exp_cycle(1, "o_b_idle_blocked", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_b_preall", PRE, 0, 0, 16'h0, 0, 1, 0, 0, 0, 0); tick();
      nops(1, 3, "o_b_trp");
      exp_cycle(1, "o_b_ref", REF, 0, 0, 16'h0, 0, 1, 0, 0, 0, 0); tick();
      nops(1, 8, "o_b_trfc");
      exp_cycle(1, "o_b_ack", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 1);
      tick();
      o_ref_req = 0; o_req_valid = 0;
      exp_cycle(1, "o_b_req_act0", ACT0, 3, 2, 16'h0077, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_b_req_act1", ACT1, 3, 2, 16'h0077, 0, 0, 0, 0, 0, 0); tick();
      exp_cycle(1, "o_b_wrcd", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);

      // Reset during WRCD clears the open row of bg3/bk2
      o_reset = 1;
      #1;
      exp_cycle(1, "o_abort", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
      tick();
      o_reset = 0;
      tick();
      exp_cycle(1, "o_post_reset", NOP, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0);
      o_req_valid = 1; o_req_op = 0; o_req_bg = 3; o_req_bank = 2;
      o_req_row = 16'h0077; o_req_col = 10'h003;
      tick();
      o_req_valid = 0;
      exp_cycle(1, "o_reissue_act0", ACT0, 3, 2, 16'h0077, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
